button_step_pulser: RTL and testbench

//  Front end for the 0..5 selector: conditions two raw push-buttons (up/down) into clean

---
 rtl/button_step_pulser.sv | 162 ++++++++++++++++
 tb/tb_button_step_pulser.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_step_pulser.sv
// Conditions two raw push-buttons into debounced levels and single-cycle inc/dec step pulses,
// with optional hold-to-repeat and mutual exclusion when both buttons are held.
module button_step_pulser #(
    parameter int DB_CYCLES     = 1_000_000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 20_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up,
    input  logic btn_down,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic up_held,
    output logic down_held
);
    localparam int DW   = $clog2(DB_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);

    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
    localparam logic [DW-1:0] DB_SAT  = {DW{1'b1}};
    localparam logic [DW-1:0] DB_ZERO = {DW{1'b0}};
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] R_ZERO  = {RW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_HELD   = 2'd3
    } state_t;

    // Index 0 is the up button, index 1 the down button throughout.
    logic [1:0]    btn_raw_s;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    stable_q;
    logic [1:0]    stable_d;
    logic [DW-1:0] db_cnt_q [2];
    logic [DW-1:0] db_cnt_d [2];
    state_t        state_q  [2];
    state_t        state_d  [2];
    logic [RW-1:0] rcnt_q   [2];
    logic [RW-1:0] rcnt_d   [2];
    logic [1:0]    fire_s;
    logic [1:0]    pulse_q;
    logic [1:0]    pulse_d;
    logic          both_held_s;

    assign btn_raw_s   = {btn_down, btn_up};
    assign both_held_s = &stable_q;

    // State registers: synchronisers, debounce, per-button FSMs and output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 2'b00;
            sync2_q  <= 2'b00;
            stable_q <= 2'b00;
            pulse_q  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= DB_ZERO;
                state_q[i]  <= ST_IDLE;
                rcnt_q[i]   <= R_ZERO;
            end
        end else begin
            sync1_q  <= btn_raw_s;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                state_q[i]  <= state_d[i];
                rcnt_q[i]   <= rcnt_d[i];
            end
        end
    end

    // Debounce: accept a level only after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = DB_ZERO;
            end else if (db_cnt_q[i] == DB_LAST) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = DB_ZERO;
            end else if (db_cnt_q[i] != DB_SAT) begin
                db_cnt_d[i] = db_cnt_q[i] + DW'(1'b1);
            end else begin
                db_cnt_d[i] = db_cnt_q[i];
            end
        end
    end

    // Per-button press/repeat FSM; holding both buttons parks both in HELD without pulsing.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            rcnt_d[i]  = rcnt_q[i];
            fire_s[i]  = 1'b0;
            if (!stable_q[i]) begin
                state_d[i] = ST_IDLE;
                rcnt_d[i]  = R_ZERO;
            end else if (both_held_s) begin
                state_d[i] = ST_HELD;
                rcnt_d[i]  = R_ZERO;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        fire_s[i]  = 1'b1;
                        rcnt_d[i]  = R_ZERO;
                        state_d[i] = (REPEAT_EN != 0) ? ST_DELAY : ST_HELD;
                    end
                    ST_DELAY: begin
                        if (rcnt_q[i] == RD_LAST) begin
                            fire_s[i]  = 1'b1;
                            rcnt_d[i]  = R_ZERO;
                            state_d[i] = ST_REPEAT;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + RW'(1'b1);
                        end
                    end
                    ST_REPEAT: begin
                        if (rcnt_q[i] == RP_LAST) begin
                            fire_s[i] = 1'b1;
                            rcnt_d[i] = R_ZERO;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + RW'(1'b1);
                        end
                    end
                    ST_HELD: begin
                        state_d[i] = ST_HELD;
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        rcnt_d[i]  = R_ZERO;
                    end
                endcase
            end
        end
    end

    // Simultaneous inc and dec requests cancel each other.
    always_comb begin
        pulse_d = 2'b00;
        if (&fire_s) begin
            pulse_d = 2'b00;
        end else begin
            pulse_d = fire_s;
        end
    end

    assign inc_pulse = pulse_q[0];
    assign dec_pulse = pulse_q[1];
    assign up_held   = stable_q[0];
    assign down_held = stable_q[1];

endmodule

// File: tb/tb_button_step_pulser.sv
// Bench for button_step_pulser: a repeating and a one-shot instance share stimulus and are
// compared each cycle against a timing model, plus vector tables and directed corner cases.
module tb_button_step_pulser;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic btn_up   = 1'b0;
    logic btn_down = 1'b0;
    logic inc_r, dec_r, uph_r, dnh_r;
    logic inc_o, dec_o, uph_o, dnh_o;

    int tests = 0;
    int fails = 0;
    int cnt_inc_r = 0, cnt_dec_r = 0, cnt_inc_o = 0, cnt_dec_o = 0;

    always #5 clk = ~clk;

    button_step_pulser #(.DB_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_rep (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
        .inc_pulse(inc_r), .dec_pulse(dec_r), .up_held(uph_r), .down_held(dnh_r));

    button_step_pulser #(.DB_CYCLES(DB), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_one (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
        .inc_pulse(inc_o), .dec_pulse(dec_o), .up_held(uph_o), .down_held(dnh_o));

    // Reference model: stable level flips once the last DB samples since the previous flip all
    // disagree; pulses are scheduled by age since the press (0, RD, RD+RP*k).
    logic m_sync1 [2];
    logic m_s     [2];
    logic m_stable[2];
    logic m_block [2];
    logic m_inc   [2];
    logic m_dec   [2];
    logic s_hist  [2][64];
    int   m_press [2];
    int   m_flip  [2];
    int   m_edge;

    task automatic model_reset();
        m_edge = 0;
        for (int i = 0; i < 2; i++) begin
            m_sync1[i] = 1'b0; m_s[i] = 1'b0; m_stable[i] = 1'b0; m_block[i] = 1'b0;
            m_inc[i] = 1'b0; m_dec[i] = 1'b0; m_press[i] = 0; m_flip[i] = -1;
        end
    endtask

    task automatic model_step();
        logic st_old[2];
        logic s_old[2];
        logic fire[2][2];
        logic raw[2];
        logic both;
        logic diff;
        int   n;
        int   a;
        n = m_edge;
        st_old = m_stable;
        s_old = m_s;
        raw[0] = btn_up;
        raw[1] = btn_down;
        both = st_old[0] && st_old[1];
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < 2; i++) begin
                fire[v][i] = 1'b0;
                if (st_old[i] && !m_block[i] && !both) begin
                    a = n - m_press[i] - 1;
                    fire[v][i] = (a == 0) || (v == 0 && a >= RD && ((a - RD) % RP) == 0);
                end
            end
            if (fire[v][0] && fire[v][1]) begin
                fire[v][0] = 1'b0;
                fire[v][1] = 1'b0;
            end
            m_inc[v] = fire[v][0];
            m_dec[v] = fire[v][1];
        end
        for (int i = 0; i < 2; i++) begin
            if (!st_old[i]) m_block[i] = 1'b0;
            else if (both) m_block[i] = 1'b1;
            s_hist[i][n % 64] = s_old[i];
            diff = 1'b0;
            if (n - m_flip[i] >= DB) begin
                diff = 1'b1;
                for (int j = 0; j < DB; j++)
                    if (s_hist[i][(n - j) % 64] == st_old[i]) diff = 1'b0;
            end
            m_s[i] = m_sync1[i];
            m_sync1[i] = raw[i];
            if (diff) begin
                m_stable[i] = !st_old[i];
                m_flip[i] = n;
                if (!st_old[i]) m_press[i] = n;
            end
        end
        m_edge = m_edge + 1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) if (rst_n) model_step();

    // Per-cycle scoreboard and pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        check("cyc_rep", int'({inc_r, dec_r, uph_r, dnh_r}),
              int'({m_inc[0], m_dec[0], m_stable[0], m_stable[1]}));
        check("cyc_one", int'({inc_o, dec_o, uph_o, dnh_o}),
              int'({m_inc[1], m_dec[1], m_stable[0], m_stable[1]}));
        if (inc_r) cnt_inc_r++;
        if (dec_r) cnt_dec_r++;
        if (inc_o) cnt_inc_o++;
        if (dec_o) cnt_dec_o++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return inc_r;
            1:       return dec_r;
            2:       return uph_r;
            default: return !dnh_r;
        endcase
    endfunction

    // Ticks until the selected condition is seen; returns budget+1 if it never appears.
    task automatic wait_for(input int sel, input int budget, output int n);
        n = 0;
        while (n <= budget) begin
            tick();
            n++;
            if (sig(sel)) break;
        end
    endtask

    typedef struct {
        logic up;
        logic down;
        int   hold;
        int   e_inc_r;
        int   e_dec_r;
        int   e_inc_o;
        int   e_dec_o;
    } vec_t;

    vec_t vecs[7];
    int   b_ir, b_dr, b_io, b_do;
    int   lat;
    int   ptimes[$];

    task automatic snap();
        b_ir = cnt_inc_r; b_dr = cnt_dec_r; b_io = cnt_inc_o; b_do = cnt_dec_o;
    endtask

    task automatic check_counts(input string name, input int ir, input int dr, input int io, input int d_o);
        check({name, "_inc_rep"}, cnt_inc_r - b_ir, ir);
        check({name, "_dec_rep"}, cnt_dec_r - b_dr, dr);
        check({name, "_inc_one"}, cnt_inc_o - b_io, io);
        check({name, "_dec_one"}, cnt_dec_o - b_do, d_o);
    endtask

    initial begin
        model_reset();
        vecs[0] = '{1'b1, 1'b0, 3,  0, 0, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 4,  1, 0, 1, 0};
        vecs[2] = '{1'b1, 1'b0, 8,  1, 0, 1, 0};
        vecs[3] = '{1'b0, 1'b1, 20, 0, 3, 0, 1};
        vecs[4] = '{1'b1, 1'b0, 20, 3, 0, 1, 0};
        vecs[5] = '{1'b1, 1'b1, 20, 0, 0, 0, 0};
        vecs[6] = '{1'b0, 1'b1, 12, 0, 2, 0, 1};

        // Reset held with up pressed, then a fresh press after release.
        btn_up = 1'b1;
        ticks(3);
        check("reset_outs", int'({inc_r, dec_r, uph_r, dnh_r, inc_o, dec_o, uph_o, dnh_o}), 0);
        rst_n = 1'b1;
        wait_for(0, 20, lat);
        check("reset_release_latency", lat, 7);
        check("reset_release_up_held", int'(uph_r), 1);
        btn_up = 1'b0;
        ticks(20);

        // Vector table: hold levels, release, let everything settle, count pulses.
        for (int k = 0; k < 7; k++) begin
            snap();
            btn_up = vecs[k].up;
            btn_down = vecs[k].down;
            ticks(vecs[k].hold);
            btn_up = 1'b0;
            btn_down = 1'b0;
            ticks(20);
            check_counts($sformatf("vec%0d", k), vecs[k].e_inc_r, vecs[k].e_dec_r,
                         vecs[k].e_inc_o, vecs[k].e_dec_o);
        end

        // Press bounce 1,0,1,0 then steady; release bounce 0,1,0 then steady.
        snap();
        btn_up = 1'b1; tick();
        btn_up = 1'b0; tick();
        btn_up = 1'b1; tick();
        btn_up = 1'b0; tick();
        check("bounce_no_early_pulse", cnt_inc_r - b_ir, 0);
        btn_up = 1'b1;
        wait_for(0, 20, lat);
        check("bounce_latency", lat, 7);
        btn_up = 1'b0; tick();
        btn_up = 1'b1; tick();
        btn_up = 1'b0;
        ticks(20);
        check_counts("bounce", 1, 0, 1, 0);
        check("bounce_up_released", int'(uph_r), 0);

        // Hold down for 40 cycles: repeat schedule and release timing.
        snap();
        ptimes.delete();
        lat = 0;
        btn_down = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            if (t == 41) btn_down = 1'b0;
            tick();
            if (dec_r) ptimes.push_back(t);
            if (t > 40 && lat == 0 && !dnh_r) lat = t - 40;
        end
        check("repeat_count", ptimes.size(), 7);
        for (int j = 0; j < ptimes.size() && j < 7; j++)
            check($sformatf("repeat_time%0d", j), ptimes[j], (j == 0) ? 7 : 7 + RD + RP * (j - 1));
        check("repeat_release_fall", lat, 6);
        check("repeat_one_shot_count", cnt_dec_o - b_do, 1);

        // Long hold: one-shot instance pulses once, repeating instance keeps going.
        snap();
        btn_up = 1'b1;
        ticks(100);
        btn_up = 1'b0;
        ticks(20);
        check_counts("long_hold", 19, 0, 1, 0);

        // Conflict: simultaneous press, then down pressed 3 cycles after up.
        snap();
        btn_up = 1'b1; btn_down = 1'b1;
        ticks(50);
        btn_up = 1'b0; btn_down = 1'b0;
        ticks(20);
        check_counts("conflict_same", 0, 0, 0, 0);
        snap();
        btn_up = 1'b1;
        ticks(3);
        btn_down = 1'b1;
        ticks(50);
        btn_down = 1'b0;
        ticks(30);
        btn_up = 1'b0;
        ticks(20);
        check_counts("conflict_stagger", 1, 0, 1, 0);

        // Async reset asserted between edges while in the repeat phase.
        btn_up = 1'b1;
        ticks(25);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_outs", int'({inc_r, dec_r, uph_r, dnh_r, inc_o, dec_o, uph_o, dnh_o}), 0);
        snap();
        btn_up = 1'b0;
        tick();
        rst_n = 1'b1;
        ticks(20);
        check_counts("async_reset_after", 0, 0, 0, 0);

        // Randomised levels and occasional resets, checked by the per-cycle scoreboard.
        for (int r = 0; r < 60; r++) begin
            btn_up = 1'($urandom_range(0, 1));
            btn_down = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 14) == 0) begin
                rst_n = 1'b0;
                ticks($urandom_range(1, 2));
                rst_n = 1'b1;
            end
            ticks($urandom_range(1, 25));
        end
        btn_up = 1'b0;
        btn_down = 1'b0;
        ticks(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
